// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer that gates the CPU commit enable and counts retired instructions.
// Define CPU_RUN_CTRL_BREAKPOINT_EN to build the PC breakpoint slots; without it bp_* inputs are ignored.
module cpu_run_ctrl #(
  parameter int BP_NUM   = 4,
  parameter int BP_IDX_W = 2,
  parameter int STEP_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [STEP_W-1:0]   cmd_arg,
  input  logic                bp_we,
  input  logic [BP_IDX_W-1:0] bp_idx,
  input  logic [31:0]         bp_addr,
  input  logic                bp_en_in,
  input  logic [31:0]         current_pc,
  output logic                cpu_en,
  output logic [1:0]          state,
  output logic [1:0]          halt_cause,
  output logic [31:0]         retired
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10
  } state_e;

  localparam logic [1:0] OP_HALT    = 2'b00;
  localparam logic [1:0] OP_RUN     = 2'b01;
  localparam logic [1:0] OP_STEPN   = 2'b11;
  localparam logic [1:0] CAUSE_CMD  = 2'b00;
  localparam logic [1:0] CAUSE_BP   = 2'b01;
  localparam logic [1:0] CAUSE_STEP = 2'b10;

  state_e            state_q, state_d;
  logic [1:0]        cause_q, cause_d;
  logic [STEP_W-1:0] remain_q, remain_d;
  logic [31:0]       retired_q;
  logic [STEP_W-1:0] new_remain_s;
  logic              cmd_acc_s;
  logic              bp_hit_s;

  assign cmd_ready    = 1'b1;
  assign cmd_acc_s    = cmd_valid && rst;
  assign new_remain_s = (cmd_op == OP_STEPN) ? cmd_arg : {{(STEP_W-1){1'b0}}, 1'b1};
  // Reset forces the CPU to hold even before the state register clears.
  assign cpu_en = rst && !bp_hit_s &&
                  ((state_q == ST_RUN) ||
                   ((state_q == ST_STEP) && (remain_q != {STEP_W{1'b0}})));

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic [29:0]       bp_addr_q [BP_NUM];
  logic [BP_NUM-1:0] bp_en_q;
  logic [BP_NUM-1:0] bp_match_s;
  logic              skip_bp_q;
  logic              unused_s;

  assign unused_s = ^{bp_addr[1:0], current_pc[1:0]};

  always_comb begin
    for (int i = 0; i < BP_NUM; i++) begin
      bp_match_s[i] = bp_en_q[i] && (bp_addr_q[i] == current_pc[31:2]);
    end
  end

  // skip_bp lets a resume from a breakpoint PC commit that instruction once.
  assign bp_hit_s = (|bp_match_s) && !skip_bp_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BP_NUM; i++) begin
        bp_addr_q[i] <= 30'd0;
        bp_en_q[i]   <= 1'b0;
      end
      skip_bp_q <= 1'b0;
    end else begin
      for (int i = 0; i < BP_NUM; i++) begin
        if (bp_we && (bp_idx == BP_IDX_W'(i))) begin
          bp_addr_q[i] <= bp_addr[31:2];
          bp_en_q[i]   <= bp_en_in;
        end
      end
      if (cpu_en) begin
        skip_bp_q <= 1'b0;
      end else if (cmd_acc_s && (state_q == ST_HALTED) && (cmd_op != OP_HALT)) begin
        skip_bp_q <= 1'b1;
      end
    end
  end
`else
  logic unused_s;

  assign unused_s = ^{bp_we, bp_idx, bp_addr, bp_en_in, current_pc};
  assign bp_hit_s = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    remain_d = remain_q;
    case (state_q)
      ST_HALTED: begin
        if (cmd_acc_s && (cmd_op == OP_RUN)) begin
          state_d = ST_RUN;
        end else if (cmd_acc_s && (cmd_op == OP_HALT)) begin
          cause_d = CAUSE_CMD;
        end else if (cmd_acc_s) begin
          remain_d = new_remain_s;
          if (new_remain_s == {STEP_W{1'b0}}) begin
            cause_d = CAUSE_STEP;
          end else begin
            state_d = ST_STEP;
          end
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_RUN, ST_STEP: begin
        // HALT wins over a breakpoint; a breakpoint wins over a reload.
        if (cmd_acc_s && (cmd_op == OP_HALT)) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_CMD;
        end else if (bp_hit_s) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end else if (cmd_acc_s && cmd_op[1]) begin
          remain_d = new_remain_s;
          if (new_remain_s == {STEP_W{1'b0}}) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_STEP;
          end else begin
            state_d = ST_STEP;
          end
        end else if ((state_q == ST_STEP) && cpu_en) begin
          remain_d = remain_q - {{(STEP_W-1){1'b0}}, 1'b1};
          if (remain_q == {{(STEP_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_STEP;
          end else begin
            state_d = ST_STEP;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_HALTED;
        cause_d = CAUSE_CMD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_HALTED;
      cause_q   <= CAUSE_CMD;
      remain_q  <= {STEP_W{1'b0}};
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      remain_q  <= remain_d;
      retired_q <= cpu_en ? (retired_q + 32'd1) : retired_q;
    end
  end

  assign state      = state_q;
  assign halt_cause = cause_q;
  assign retired    = retired_q;

endmodule
